// File: rtl/ibex_dummy_reseed_ctrl.sv
// Reseed sequencer for the dummy instruction generator: counts accepted dummy
// insertions, fetches entropy over req/ack and loads it (or a software seed) into the generator.
module ibex_dummy_reseed_ctrl #(
    parameter int unsigned ReseedInterval = 256,
    parameter int unsigned EntropyTimeout = 1023
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        csr_dummy_en_i,
    input  logic [2:0]  csr_mask_i,
    input  logic        csr_seed_wr_i,
    input  logic [31:0] csr_seed_i,
    input  logic        csr_reseed_req_i,
    input  logic        csr_err_clr_i,
    input  logic        insert_dummy_instr_i,
    input  logic        id_in_ready_i,
    output logic        entropy_req_o,
    input  logic        entropy_ack_i,
    input  logic [31:0] entropy_data_i,
    output logic        dummy_instr_en_o,
    output logic [2:0]  dummy_instr_mask_o,
    output logic        dummy_instr_seed_en_o,
    output logic [31:0] dummy_instr_seed_o,
    output logic        busy_o,
    output logic        reseed_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2
    } state_e;

    localparam logic [15:0] IvlLast = 16'(ReseedInterval - 1);
    localparam logic [15:0] ToLast  = 16'(EntropyTimeout - 1);

    state_e      state_q;
    logic [15:0] ivl_cnt_q;
    logic [15:0] to_cnt_q;
    logic [31:0] ent_q;
    logic [31:0] sw_seed_q;
    logic        sw_pend_q;
    logic [2:0]  mask_q;
    logic        err_q;

    logic accept;
    logic trigger;
    logic timeout;

    assign accept  = insert_dummy_instr_i & id_in_ready_i & csr_dummy_en_i;
    assign trigger = (state_q == IDLE) &
                     ((accept & (ivl_cnt_q == IvlLast)) | csr_reseed_req_i);
    // An ack arriving in the last allowed cycle wins over the timeout.
    assign timeout = (state_q == REQ) & ~entropy_ack_i & (to_cnt_q == ToLast);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ivl_cnt_q <= '0;
            to_cnt_q  <= '0;
            ent_q     <= '0;
            sw_seed_q <= '0;
            sw_pend_q <= 1'b0;
            mask_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            sw_pend_q <= csr_seed_wr_i;
            if (csr_seed_wr_i) begin
                sw_seed_q <= csr_seed_i;
            end

            if (timeout) begin
                err_q <= 1'b1;
            end else if (csr_err_clr_i) begin
                err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    mask_q <= csr_mask_i;
                    if (trigger || csr_seed_wr_i) begin
                        ivl_cnt_q <= '0;
                    end else if (accept) begin
                        ivl_cnt_q <= ivl_cnt_q + 16'd1;
                    end
                    if (trigger) begin
                        state_q  <= REQ;
                        to_cnt_q <= '0;
                    end
                end
                REQ: begin
                    if (entropy_ack_i) begin
                        ent_q   <= entropy_data_i;
                        state_q <= LOAD;
                    end else if (to_cnt_q == ToLast) begin
                        state_q <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                LOAD: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Entropy and software seed landing together are XOR-combined into one load.
    assign dummy_instr_seed_en_o = (state_q == LOAD) | sw_pend_q;
    assign dummy_instr_seed_o    = ({32{state_q == LOAD}} & ent_q) ^ ({32{sw_pend_q}} & sw_seed_q);
    assign entropy_req_o         = (state_q == REQ);
    assign busy_o                = (state_q != IDLE);
    assign dummy_instr_en_o      = csr_dummy_en_i & (state_q == IDLE);
    assign dummy_instr_mask_o    = mask_q;
    assign reseed_err_o          = err_q;

endmodule
